mult_iter: RTL and testbench

Parametrised iterative multiplier for the Karatsuba datapath. It computes a WIDTH×WIDTH product, signed or unsigned, over several cycles, processing one DIGIT-wide slice of B per cycle. It generalises the fixed 18-bit leaf multiplier to arbitrary widths with a DSP-sized digit and a selectable signed mode. It keeps the same level-sensitive start/done handshake, so upper Karatsuba stages can instantiate it directly as a leaf or mid-level multiplier.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_digit.sv | 14 +
 rtl/mult_iter.sv | 144 ++++++++++++++
 tb/tb_mult_iter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the iterative multiplier and the
// Karatsuba stages built on top of it.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  function automatic int mult_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-digit configuration still needs a 1-bit counter.
  function automatic int mult_sel_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/mult_digit.sv
// Combinational WIDTH x DIGIT unsigned partial product, sized to map onto
// DSP tiles.
module mult_digit #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 16
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [DIGIT-1:0]       b,
  output logic [WIDTH+DIGIT-1:0] pp
);

  assign pp = (WIDTH+DIGIT)'(a) * (WIDTH+DIGIT)'(b);

endmodule

// File: rtl/mult_iter.sv
// Iterative WIDTH x WIDTH multiplier, signed or unsigned, one DIGIT slice of
// B per cycle with a level-sensitive start/done handshake.
module mult_iter
  import mult_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  localparam int NDIG  = mult_ndig(WIDTH, DIGIT);
  localparam int SEL_W = mult_sel_w(NDIG);
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] CNT_END = SEL_W'(NDIG - 1);

  if (WIDTH % DIGIT != 0) begin : g_width_check
    $error("mult_iter: WIDTH must be a multiple of DIGIT");
  end

  mult_state_t          state_r, state_s;
  logic [WIDTH-1:0]     a_mag_r, b_mag_r;
  logic                 neg_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [SEL_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   p_r;
  logic                 done_r, busy_r;

  logic                 a_neg_s, b_neg_s;
  logic [WIDTH-1:0]     a_mag_s, b_mag_s;
  logic [31:0]          off_s;
  logic [DIGIT-1:0]     b_dig_s;
  logic [WIDTH+DIGIT-1:0] pp_s;
  logic [2*WIDTH-1:0]   pp_shift_s;

  // The most-negative operand negates to itself, which read unsigned is
  // exactly its magnitude.
  assign a_neg_s = is_signed & A[WIDTH-1];
  assign b_neg_s = is_signed & B[WIDTH-1];
  assign a_mag_s = a_neg_s ? (~A + ONE_W) : A;
  assign b_mag_s = b_neg_s ? (~B + ONE_W) : B;

  assign off_s      = 32'(cnt_r) * 32'(DIGIT);
  assign b_dig_s    = b_mag_r[off_s +: DIGIT];
  assign pp_shift_s = (2*WIDTH)'(pp_s) << off_s;

  mult_digit #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_digit (
    .a  (a_mag_r),
    .b  (b_dig_s),
    .pp (pp_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (cnt_r == CNT_END) state_s = FIX;
        else                  state_s = RUN;
      end
      FIX:  state_s = DONE;
      DONE: begin
        if (!start) state_s = IDLE;
        else        state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, accumulation, sign correction and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_mag_r <= '0;
      b_mag_r <= '0;
      neg_r   <= 1'b0;
      acc_r   <= '0;
      cnt_r   <= '0;
      p_r     <= '0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_mag_r <= a_mag_s;
            b_mag_r <= b_mag_s;
            neg_r   <= a_neg_s ^ b_neg_s;
            acc_r   <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          acc_r <= acc_r + pp_shift_s;
          cnt_r <= cnt_r + SEL_W'(1);
        end
        FIX: begin
          p_r    <= neg_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
          done_r <= 1'b1;
          cnt_r  <= '0;
        end
        DONE: begin
          if (!start) begin
            done_r <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        default: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign P    = p_r;
  assign done = done_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_mult_iter.sv
// Scoreboard bench for mult_iter: a 64/16 instance and a 36/18 instance.
module tb_mult_iter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         start64 = 1'b0, sg64 = 1'b0;
  logic [63:0]  a64 = '0, b64 = '0;
  logic         busy64, done64;
  logic [127:0] p64;

  logic         start36 = 1'b0, sg36 = 1'b0;
  logic [35:0]  a36 = '0, b36 = '0;
  logic         busy36, done36;
  logic [71:0]  p36;

  int errors = 0;
  int checks = 0;
  logic [127:0] q64[$];
  logic [127:0] q36[$];
  logic [127:0] mask72;
  logic [127:0] held;

  always #5 clk = ~clk;

  mult_iter #(.WIDTH(64), .DIGIT(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .is_signed(sg64),
    .A(a64), .B(b64), .busy(busy64), .done(done64), .P(p64)
  );

  mult_iter #(.WIDTH(36), .DIGIT(18)) u_dut36 (
    .clk(clk), .rst_n(rst_n), .start(start36), .is_signed(sg36),
    .A(a36), .B(b36), .busy(busy36), .done(done36), .P(p36)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference product: sign-extend from bit w-1 and multiply in 128 bits.
  function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input bit sg, input int w);
    logic signed [127:0] sa, sb;
    sa = 128'(a);
    sb = 128'(b);
    if (sg && a[w-1]) sa = sa | (~128'd0 << w);
    if (sg && b[w-1]) sb = sb | (~128'd0 << w);
    return sa * sb;
  endfunction

  task automatic launch(input bit w36, input logic [63:0] a, input logic [63:0] b, input bit sg);
    if (w36) begin
      a36 = a[35:0]; b36 = b[35:0]; sg36 = sg; start36 = 1'b1;
      q36.push_back(model(a, b, sg, 36) & mask72);
    end else begin
      a64 = a; b64 = b; sg64 = sg; start64 = 1'b1;
      q64.push_back(model(a, b, sg, 64));
    end
    tick;
    check("busy_after_launch", 128'(w36 ? busy36 : busy64), 128'd1);
  endtask

  task automatic wait_done(input bit w36, input string tag, input int lat_exp,
                           output logic [127:0] exp);
    int lat;
    logic [127:0] got;
    lat = 0;
    while (!(w36 ? done36 : done64) && lat < 40) begin
      tick;
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(lat_exp));
    got = w36 ? 128'(p36) : p64;
    exp = '0;
    if (w36 && q36.size() > 0)       exp = q36.pop_front();
    else if (!w36 && q64.size() > 0) exp = q64.pop_front();
    check(tag, got, exp);
  endtask

  task automatic release_op(input bit w36, input string tag);
    if (w36) start36 = 1'b0; else start64 = 1'b0;
    tick;
    check({tag, "_done_clear"}, 128'(w36 ? done36 : done64), 128'd0);
    check({tag, "_busy_clear"}, 128'(w36 ? busy36 : busy64), 128'd0);
  endtask

  task automatic op64(input logic [63:0] a, input logic [63:0] b, input bit sg, input string tag);
    logic [127:0] e;
    launch(1'b0, a, b, sg);
    wait_done(1'b0, tag, 5, e);
    release_op(1'b0, tag);
  endtask

  initial begin
    logic [127:0] e;
    mask72 = {56'd0, {72{1'b1}}};

    tick;
    tick;
    check("reset_p", p64, 128'd0);
    check("reset_done", 128'(done64), 128'd0);
    check("reset_busy", 128'(busy64), 128'd0);
    rst_n = 1'b1;
    tick;

    op64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "umax");
    check("umax_const", p64, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    op64(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b1, "smixed");
    check("smixed_const", p64, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB);
    op64(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b0, "umixed");
    op64(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, "scorner");
    check("scorner_const", p64, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
    op64(64'h8000_0000_0000_0000, 64'd3, 1'b1, "sneg_pos");
    op64(64'd0, 64'h1234_5678_9ABC_DEF0, 1'b1, "zero");

    // Start held high; operand changes after launch must be ignored.
    launch(1'b0, 64'd1000003, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    a64 = 64'hDEAD_BEEF_0000_0001; b64 = 64'd5; sg64 = 1'b0;
    wait_done(1'b0, "hold", 5, held);
    for (int i = 0; i < 20; i++) begin
      tick;
      if (done64 !== 1'b1 || p64 !== held) check("hold_stable", p64, held);
    end
    check("hold_done_high", 128'(done64), 128'd1);
    check("hold_p_stable", p64, held);
    release_op(1'b0, "hold");
    op64(64'd77, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, "rearm");

    // Asynchronous reset during the second RUN cycle.
    launch(1'b0, 64'hAAAA_5555_AAAA_5555, 64'h1357_9BDF_2468_ACE0, 1'b0);
    tick;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_p", p64, 128'd0);
    check("midrst_done", 128'(done64), 128'd0);
    check("midrst_busy", 128'(busy64), 128'd0);
    q64.delete();
    start64 = 1'b0;
    tick;
    #2 rst_n = 1'b1;
    tick;
    op64(64'd12345, 64'd6789, 1'b0, "post_rst");
    check("post_rst_const", p64, 128'd83810205);

    // Start dropped right after launch: done must be a single-cycle pulse.
    launch(1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1);
    start64 = 1'b0;
    wait_done(1'b0, "drop64", 5, e);
    tick;
    check("drop64_pulse", 128'(done64), 128'd0);
    check("drop64_busy", 128'(busy64), 128'd0);

    for (int i = 0; i < 8; i++) begin
      op64({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), "rand64");
    end

    // 36/18 variant.
    launch(1'b1, 64'hF_FFFF_FFFF, 64'hF_FFFF_FFFF, 1'b0);
    start36 = 1'b0;
    wait_done(1'b1, "w36_max", 3, e);
    check("w36_max_const", 128'(p36), 128'hFF_FFFF_FFE0_0000_0001);
    tick;
    check("w36_pulse", 128'(done36), 128'd0);
    check("w36_busy", 128'(busy36), 128'd0);
    launch(1'b1, 64'hF_FFFF_FFFF, 64'h8_0000_0000, 1'b1);
    wait_done(1'b1, "w36_signed", 3, e);
    release_op(1'b1, "w36_signed");
    launch(1'b1, 64'h9_8765_4321, 64'h0_1234_5678, 1'b1);
    wait_done(1'b1, "w36_mix", 3, e);
    release_op(1'b1, "w36_mix");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
